// File: rtl/dram_bus.sv
// dram_bus: valid/ready data memory with byte/half/word lanes, sign/zero-extended loads and configurable latency.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   req_valid/req_ready  request handshake; ready only while idle
//   req_we         1 = store, 0 = load
//   req_size       0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned   zero-extend sub-word loads when set
//   req_adr        byte address, aliases modulo DEPTH_WORDS*4
//   req_wdata      right-aligned store data
//   rsp_valid      one-cycle response pulse
//   rsp_rdata      extended load data, 0 for stores and errors
//   rsp_err        misaligned or illegal-size request
// Option: define DRAM_ALIGN_CHECK_EN to flag misaligned/size-3 requests; otherwise low address bits are
// forced to the access size, size 3 acts as word and rsp_err stays 0.
module dram_bus #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic r_we, r_uns, r_err;
  logic [1:0] r_size;
  logic [ADDR_W-1:0] r_adr;
  logic [31:0] r_wdata, r_rdata;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic w_commit, w_err, w_unused;
  logic [1:0] w_size, w_lo;
  logic [3:0] w_be;
  logic [IDX_W-1:0] w_idx;
  logic [31:0] w_old, w_sh, w_wpos, w_load, w_rd;
  assign req_ready = r_state == IDLE;
  assign rsp_valid = r_state == RESP;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign w_commit  = r_state == WAIT && r_cnt == 4'd0;
  assign w_idx     = r_adr[IDX_W+1:2];
  assign w_unused  = &{1'b0, r_adr[ADDR_W-1:IDX_W+2]};
`ifdef DRAM_ALIGN_CHECK_EN
  assign w_size = r_size;
  assign w_lo   = r_adr[1:0];
  assign w_err  = r_size == 2'd3 || (r_size == 2'd1 && r_adr[0]) || (r_size == 2'd2 && r_adr[1:0] != 2'd0);
`else
  assign w_size = r_size == 2'd3 ? 2'd2 : r_size;
  assign w_lo   = w_size == 2'd0 ? r_adr[1:0] : w_size == 2'd1 ? {r_adr[1], 1'b0} : 2'd0;
  assign w_err  = 1'b0;
`endif
  assign w_old = r_mem[w_idx];
  assign w_sh  = w_old >> {w_lo, 3'b000};
  // Replicate sub-word data across all lanes; the byte enables pick the addressed ones.
  assign w_be   = w_size == 2'd0 ? 4'b0001 << w_lo : w_size == 2'd1 ? 4'b0011 << w_lo : 4'b1111;
  assign w_wpos = w_size == 2'd0 ? {4{r_wdata[7:0]}} : w_size == 2'd1 ? {2{r_wdata[15:0]}} : r_wdata;
  assign w_load = w_size == 2'd0 ? {{24{~r_uns & w_sh[7]}}, w_sh[7:0]}
                : w_size == 2'd1 ? {{16{~r_uns & w_sh[15]}}, w_sh[15:0]} : w_old;
  assign w_rd   = (r_we || w_err) ? 32'd0 : w_load;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && req_valid) w_next = WAIT;
    else if (w_commit) w_next = RESP;
    else if (r_state == RESP) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req_valid) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_adr   <= req_adr;
        r_wdata <= req_wdata;
        r_cnt   <= 4'(LATENCY);
      end else if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_commit) begin
        r_rdata <= w_rd;
        r_err   <= w_err;
      end
    end
  end
  // A reset landing on the commit edge cancels the store.
  always_ff @(posedge clk) begin
    if (w_commit && r_we && !w_err && !rst)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wpos[8*b +: 8];
  end
endmodule

// File: tb/tb_dram_bus.sv
// tb_dram_bus: scoreboard bench for dram_bus with a LATENCY=2 and a LATENCY=0 instance.
module tb_dram_bus;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    string       name;
  } exp_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [1:0] v = 2'b00, we = 2'b00, un = 2'b00;
  logic [1:0] sz [2];
  logic [15:0] ad [2];
  logic [31:0] wd [2];
  logic rdy_a, rv_a, re_a, rdy_b, rv_b, re_b;
  logic [31:0] rd_a, rd_b;
  int cyc = 0, tests = 0, fails = 0;
  exp_t qa[$], qb[$];
  always @(posedge clk) cyc <= cyc + 1;

  dram_bus #(.ADDR_W(16), .DEPTH_WORDS(4096), .LATENCY(2)) u_a (
    .clk(clk), .rst(rst), .req_valid(v[0]), .req_ready(rdy_a), .req_we(we[0]), .req_size(sz[0]),
    .req_unsigned(un[0]), .req_adr(ad[0]), .req_wdata(wd[0]), .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(re_a));
  dram_bus #(.ADDR_W(16), .DEPTH_WORDS(4096), .LATENCY(0)) u_b (
    .clk(clk), .rst(rst), .req_valid(v[1]), .req_ready(rdy_b), .req_we(we[1]), .req_size(sz[1]),
    .req_unsigned(un[1]), .req_adr(ad[1]), .req_wdata(wd[1]), .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(re_b));

  task automatic expect_eq(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", nm, act, req);
    end
  endtask

  task automatic chk(input int d, input logic [31:0] rd, input logic er);
    exp_t e;
    int lat;
    tests++;
    if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
      fails++;
      $display("FAIL unexpected_rsp dut%0d got rdata=%h err=%b expected no response", d, rd, er);
    end else begin
      if (d == 0) e = qa.pop_front();
      else e = qb.pop_front();
      lat = cyc - e.acc;
      if (rd !== e.rdata || er !== e.err || lat != (d == 0 ? 3 : 1)) begin
        fails++;
        $display("FAIL %s dut%0d got rdata=%h err=%b lat=%0d expected rdata=%h err=%b lat=%0d",
                 e.name, d, rd, er, lat, e.rdata, e.err, d == 0 ? 3 : 1);
      end
    end
  endtask

  always @(negedge clk) if (!rst && rv_a) chk(0, rd_a, re_a);
  always @(negedge clk) if (!rst && rv_b) chk(1, rd_b, re_b);

  task automatic push(input int d, input string nm, input logic [31:0] er, input logic ee);
    exp_t e;
    e.rdata = er; e.err = ee; e.acc = cyc + 1; e.name = nm;
    if (d == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  task automatic issue(input int d, input string nm, input logic w, input logic [1:0] s, input logic u,
                       input logic [15:0] a, input logic [31:0] dat, input logic [31:0] er, input logic ee);
    int n = 0;
    @(negedge clk);
    v[d] = 1'b1; we[d] = w; sz[d] = s; un[d] = u; ad[d] = a; wd[d] = dat;
    while (!(d == 0 ? rdy_a : rdy_b) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL %s_accept_timeout got ready=0 expected ready=1", nm);
    end else push(d, nm, er, ee);
    @(negedge clk);
    v[d] = 1'b0;
    expect_eq({nm, "_busy"}, {31'd0, d == 0 ? rdy_a : rdy_b}, 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (qa.size() + qb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL drain_timeout got pending=%0d expected pending=0", qa.size() + qb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      sz[i] = 2'd0; ad[i] = 16'd0; wd[i] = 32'd0;
    end
    repeat (2) @(negedge clk);
    expect_eq("rst_ready", {31'd0, rdy_a}, 32'd1);
    expect_eq("rst_rsp_valid", {31'd0, rv_a}, 32'd0);
    expect_eq("rst_rdata", rd_a, 32'd0);
    expect_eq("rst_err", {31'd0, re_a}, 32'd0);
    expect_eq("rst_ready_b", {31'd0, rdy_b}, 32'd1);
    rst = 0;
    issue(0, "st_w_10", 1, 2'd2, 0, 16'h0010, 32'hDEADBEEF, 32'h0, 0);
    issue(0, "ld_w_10", 0, 2'd2, 0, 16'h0010, 32'h0, 32'hDEADBEEF, 0);
    issue(0, "st_w_20", 1, 2'd2, 0, 16'h0020, 32'h11223344, 32'h0, 0);
    issue(0, "st_b_21", 1, 2'd0, 0, 16'h0021, 32'hFFFFFFAA, 32'h0, 0);
    issue(0, "ld_w_20a", 0, 2'd2, 0, 16'h0020, 32'h0, 32'h1122AA44, 0);
    issue(0, "ld_bs_21", 0, 2'd0, 0, 16'h0021, 32'h0, 32'hFFFFFFAA, 0);
    issue(0, "ld_bu_21", 0, 2'd0, 1, 16'h0021, 32'h0, 32'h000000AA, 0);
    issue(0, "st_h_22", 1, 2'd1, 0, 16'h0022, 32'hFFFF8001, 32'h0, 0);
    issue(0, "ld_w_20b", 0, 2'd2, 0, 16'h0020, 32'h0, 32'h8001AA44, 0);
    issue(0, "ld_hs_22", 0, 2'd1, 0, 16'h0022, 32'h0, 32'hFFFF8001, 0);
    issue(0, "ld_hu_22", 0, 2'd1, 1, 16'h0022, 32'h0, 32'h00008001, 0);
    issue(0, "st_h_22b", 1, 2'd1, 0, 16'h0022, 32'h00005566, 32'h0, 0);
    issue(0, "ld_w_20c", 0, 2'd2, 1, 16'h0020, 32'h0, 32'h5566AA44, 0);
    issue(0, "st_w_30", 1, 2'd2, 0, 16'h0030, 32'hCAFEF00D, 32'h0, 0);
`ifdef DRAM_ALIGN_CHECK_EN
    issue(0, "st_w_31", 1, 2'd2, 0, 16'h0031, 32'h12345678, 32'h0, 1);
    issue(0, "ld_w_30", 0, 2'd2, 0, 16'h0030, 32'h0, 32'hCAFEF00D, 0);
    issue(0, "ld_sz3_30", 0, 2'd3, 0, 16'h0030, 32'h0, 32'h0, 1);
    issue(0, "ld_h_33", 0, 2'd1, 0, 16'h0033, 32'h0, 32'h0, 1);
`else
    issue(0, "st_w_31", 1, 2'd2, 0, 16'h0031, 32'h12345678, 32'h0, 0);
    issue(0, "ld_w_30", 0, 2'd2, 0, 16'h0030, 32'h0, 32'h12345678, 0);
    issue(0, "ld_sz3_30", 0, 2'd3, 0, 16'h0030, 32'h0, 32'h12345678, 0);
    issue(0, "ld_h_33", 0, 2'd1, 0, 16'h0033, 32'h0, 32'h00001234, 0);
`endif
    issue(0, "st_w_4004", 1, 2'd2, 0, 16'h4004, 32'h0BADF00D, 32'h0, 0);
    issue(0, "ld_w_0004", 0, 2'd2, 0, 16'h0004, 32'h0, 32'h0BADF00D, 0);
    drain();
    @(negedge clk);
    v[0] = 1; we[0] = 0; sz[0] = 2'd2; un[0] = 0; ad[0] = 16'h0010;
    for (int k = 0; k < 12; k++) begin
      expect_eq($sformatf("held_ready_%0d", k), {31'd0, rdy_a}, {31'd0, k % 5 == 0});
      if (rdy_a) push(0, "held_ld_10", 32'hDEADBEEF, 0);
      @(negedge clk);
    end
    v[0] = 0;
    drain();
    issue(0, "st_w_40", 1, 2'd2, 0, 16'h0040, 32'h01020304, 32'h0, 0);
    drain();
    for (int dl = 0; dl <= 2; dl += 2) begin
      @(negedge clk);
      @(negedge clk);
      v[0] = 1; we[0] = 1; sz[0] = 2'd2; ad[0] = 16'h0040; wd[0] = 32'h99999999;
      @(negedge clk);
      v[0] = 0;
      repeat (dl) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      expect_eq($sformatf("rst_wait%0d_ready", dl), {31'd0, rdy_a}, 32'd1);
      repeat (4) @(negedge clk);
      issue(0, $sformatf("ld_w_40_after_rst%0d", dl), 0, 2'd2, 0, 16'h0040, 32'h0, 32'h01020304, 0);
      drain();
    end
    issue(1, "b_st_w_08", 1, 2'd2, 0, 16'h0008, 32'hA5A5A5A5, 32'h0, 0);
    issue(1, "b_ld_w_08", 0, 2'd2, 0, 16'h0008, 32'h0, 32'hA5A5A5A5, 0);
    issue(1, "b_ld_bs_0b", 0, 2'd0, 0, 16'h000B, 32'h0, 32'hFFFFFFA5, 0);
    issue(1, "b_ld_hu_08", 0, 2'd1, 1, 16'h0008, 32'h0, 32'h0000A5A5, 0);
    drain();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
